// File: rtl/xstep_pkg.sv
// Shared definitions for the xstep step-sequence scheduler: register map,
// control bit positions, step-entry layout and FSM state encoding.
package xstep_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LED_W    = 8;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned REST_BIT = 31;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_TEMPO  = 1;
  localparam int unsigned REG_GATE   = 2;
  localparam int unsigned REG_LEN    = 3;
  localparam int unsigned REG_STATUS = 4;
  localparam int unsigned TBL_BASE   = 8;

  localparam int unsigned CTRL_RUN      = 0;
  localparam int unsigned CTRL_LOOP     = 1;
  localparam int unsigned CTRL_CLR_DONE = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/xstep_table.sv
// Step table: one CPU write/read port and one scheduler read port, both with
// registered read-first outputs so the array maps onto FPGA RAM.
module xstep_table
  import xstep_pkg::*;
#(
  parameter int unsigned N_STEPS = 16
) (
  input  logic                       clk,
  input  logic                       cpu_we,
  input  logic                       cpu_re,
  input  logic [$clog2(N_STEPS)-1:0] cpu_idx,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  input  logic                       sch_re,
  input  logic [$clog2(N_STEPS)-1:0] sch_idx,
  output logic [DATA_W-1:0]          sch_rdata
);

  logic [DATA_W-1:0] mem [N_STEPS];

  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_idx] <= cpu_wdata;
    if (cpu_re) cpu_rdata <= mem[cpu_idx];
    if (sch_re) sch_rdata <= mem[sch_idx];
  end

endmodule

// File: rtl/xstep_scheduler.sv
// Memory-mapped step-sequence scheduler: register file, tick/step counters and
// the play FSM driving the tone generator and LED outputs.
module xstep_scheduler
  import xstep_pkg::*;
#(
  parameter int unsigned N_STEPS = 16,
  parameter int unsigned TICK_W  = 24,
  parameter int unsigned FREQ_W  = 16,
  parameter int unsigned LOC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [LOC_W-1:0]  addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_vld,
  output logic [LED_W-1:0]  led_out,
  output logic              busy,
  output logic              done_irq
);

  localparam int unsigned IDX_W = $clog2(N_STEPS);

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  step, step_nxt, last_step, fetch_idx;
  logic [TICK_W-1:0] tick, tick_nxt, tempo, gate, tempo_eff;
  logic [LEN_W-1:0]  len;
  logic              run, run_nxt, loop, done, done_nxt, fetch_en;
  logic              step_end, gap_start;
  logic [DATA_W-1:0] entry, tbl_rdata, reg_rdata, reg_rdata_nxt;
  logic              rd_tbl;
  logic [FREQ_W-1:0] freq_nxt;
  logic [LED_W-1:0]  led_nxt;
  logic [LOC_W-1:0]  tbl_off;
  logic              tbl_hit, rd_req, wr_req, ctrl_wr;
  logic              unused_entry;

  assign rd_req  = sel & ~we;
  assign wr_req  = sel & we;
  assign tbl_off = addr - LOC_W'(TBL_BASE);
  assign tbl_hit = (addr >= LOC_W'(TBL_BASE)) && (32'(tbl_off) < N_STEPS);
  assign ctrl_wr = wr_req && (addr == LOC_W'(REG_CTRL));
  assign unused_entry = ^entry[REST_BIT-1:FREQ_W+LED_W];

  xstep_table #(.N_STEPS(N_STEPS)) u_table (
    .clk       (clk),
    .cpu_we    (wr_req & tbl_hit),
    .cpu_re    (rd_req & tbl_hit),
    .cpu_idx   (tbl_off[IDX_W-1:0]),
    .cpu_wdata (data_in),
    .cpu_rdata (tbl_rdata),
    .sch_re    (fetch_en),
    .sch_idx   (fetch_idx),
    .sch_rdata (entry)
  );

  // TEMPO and LEN are compared live every cycle, so >= keeps a shortened step/sequence ending promptly.
  always_comb begin
    tempo_eff = (tempo == '0) ? TICK_W'(1) : tempo;
    if (len == '0)                    last_step = '0;
    else if (len >= LEN_W'(N_STEPS))  last_step = '1;
    else                              last_step = IDX_W'(len - LEN_W'(1));
  end

  assign step_end  = (state == S_PLAY || state == S_GAP) && (tick >= tempo_eff - TICK_W'(1));
  assign gap_start = (gate != '0) && (gate < tempo_eff) && (tick >= gate - TICK_W'(1));

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    tick_nxt  = tick;
    run_nxt   = run;
    done_nxt  = done;
    fetch_en  = 1'b0;
    fetch_idx = step;
    case (state)
      S_PLAY, S_GAP: begin
        tick_nxt = tick + TICK_W'(1);
        if (step_end) begin
          tick_nxt = '0;
          if (step >= last_step) begin
            if (loop) begin
              step_nxt  = '0;
              state_nxt = S_PLAY;
              fetch_en  = 1'b1;
              fetch_idx = '0;
            end else begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
              run_nxt   = 1'b0;
            end
          end else begin
            step_nxt  = step + IDX_W'(1);
            state_nxt = S_PLAY;
            fetch_en  = 1'b1;
            fetch_idx = step + IDX_W'(1);
          end
        end else if (state == S_PLAY && gap_start) begin
          state_nxt = S_GAP;
        end
      end
      default: ;
    endcase

    // CPU control writes take priority over the sequencer's own progress.
    if (ctrl_wr) begin
      if (data_in[CTRL_CLR_DONE]) done_nxt = 1'b0;
      if (!data_in[CTRL_RUN]) begin
        run_nxt   = 1'b0;
        state_nxt = S_IDLE;
        step_nxt  = '0;
        tick_nxt  = '0;
        fetch_en  = 1'b0;
      end else if (!run) begin
        run_nxt   = 1'b1;
        state_nxt = S_PLAY;
        step_nxt  = '0;
        tick_nxt  = '0;
        fetch_en  = 1'b1;
        fetch_idx = '0;
      end
    end

    freq_nxt = '0;
    led_nxt  = '0;
    if (state == S_PLAY || state == S_GAP) led_nxt = entry[FREQ_W +: LED_W];
    if (state == S_PLAY && !entry[REST_BIT] && gate != '0) freq_nxt = entry[FREQ_W-1:0];

    reg_rdata_nxt = '0;
    if (addr == LOC_W'(REG_CTRL))        reg_rdata_nxt = DATA_W'({done, loop, run});
    else if (addr == LOC_W'(REG_TEMPO))  reg_rdata_nxt = DATA_W'(tempo);
    else if (addr == LOC_W'(REG_GATE))   reg_rdata_nxt = DATA_W'(gate);
    else if (addr == LOC_W'(REG_LEN))    reg_rdata_nxt = DATA_W'(len);
    else if (addr == LOC_W'(REG_STATUS)) reg_rdata_nxt = DATA_W'({state, step});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      step      <= '0;
      tick      <= '0;
      run       <= 1'b0;
      loop      <= 1'b0;
      done      <= 1'b0;
      tempo     <= TICK_W'(1);
      gate      <= TICK_W'(1);
      len       <= LEN_W'(1);
      freq_out  <= '0;
      freq_vld  <= 1'b0;
      led_out   <= '0;
      rd_tbl    <= 1'b0;
      reg_rdata <= '0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      tick     <= tick_nxt;
      run      <= run_nxt;
      done     <= done_nxt;
      if (ctrl_wr) loop <= data_in[CTRL_LOOP];
      if (wr_req && addr == LOC_W'(REG_TEMPO)) tempo <= data_in[TICK_W-1:0];
      if (wr_req && addr == LOC_W'(REG_GATE))  gate  <= data_in[TICK_W-1:0];
      if (wr_req && addr == LOC_W'(REG_LEN))   len   <= data_in[LEN_W-1:0];
      freq_out <= freq_nxt;
      freq_vld <= (freq_nxt != freq_out);
      led_out  <= led_nxt;
      if (rd_req) begin
        rd_tbl    <= tbl_hit;
        reg_rdata <= reg_rdata_nxt;
      end
    end
  end

  assign data_out = rd_tbl ? tbl_rdata : reg_rdata;
  assign busy     = (state == S_PLAY) || (state == S_GAP);
  assign done_irq = done;

endmodule

// File: tb/tb_xstep_scheduler.sv
// Directed self-checking bench for xstep_scheduler; inputs change and outputs
// are sampled on the falling clock edge.
module tb_xstep_scheduler;
  import xstep_pkg::*;

  localparam int unsigned N_STEPS = 16;
  localparam int unsigned TICK_W  = 24;
  localparam int unsigned FREQ_W  = 16;
  localparam int unsigned LOC_W   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sel = 1'b0;
  logic              we  = 1'b0;
  logic [LOC_W-1:0]  addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [FREQ_W-1:0] freq_out;
  logic              freq_vld;
  logic [7:0]        led_out;
  logic              busy;
  logic              done_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xstep_scheduler #(
    .N_STEPS (N_STEPS),
    .TICK_W  (TICK_W),
    .FREQ_W  (FREQ_W),
    .LOC_W   (LOC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .freq_out (freq_out),
    .freq_vld (freq_vld),
    .led_out  (led_out),
    .busy     (busy),
    .done_irq (done_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = LOC_W'(a); data_in = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int unsigned a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = LOC_W'(a);
    @(negedge clk);
    sel = 1'b0;
    d = data_out;
  endtask

  function automatic logic [31:0] ent(input logic rest, input logic [7:0] leds, input logic [15:0] f);
    return {rest, 7'd0, leds, f};
  endfunction

  initial begin
    logic [31:0] rv;
    int vld_cnt;
    int st;
    int ph;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_freq", freq_out, 0);
    chk("rst_led", led_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_irq, 0);
    chk("rst_data", data_out, 0);
    rst = 1'b1;
    @(negedge clk);
    rd(REG_TEMPO, rv);  chk("rst_tempo", rv, 1);
    rd(REG_GATE, rv);   chk("rst_gate", rv, 1);
    rd(REG_LEN, rv);    chk("rst_len", rv, 1);
    rd(REG_CTRL, rv);   chk("rst_ctrl", rv, 0);
    rd(REG_STATUS, rv); chk("rst_status", rv, 0);

    // Legato one-shot of three steps
    wr(REG_TEMPO, 4); wr(REG_GATE, 4); wr(REG_LEN, 3);
    wr(TBL_BASE + 0, ent(1'b0, 8'h11, 16'd100));
    wr(TBL_BASE + 1, ent(1'b0, 8'h22, 16'd200));
    wr(TBL_BASE + 2, ent(1'b0, 8'h33, 16'd300));
    wr(REG_CTRL, 1);
    chk("t1_busy_start", busy, 1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("t1_freq", freq_out, (k <= 4) ? 100 : (k <= 8) ? 200 : (k <= 12) ? 300 : 0);
      chk("t1_led", led_out, (k <= 4) ? 32'h11 : (k <= 8) ? 32'h22 : (k <= 12) ? 32'h33 : 0);
      chk("t1_busy", busy, (k < 12) ? 1 : 0);
      chk("t1_vld", freq_vld, (k == 1 || k == 5 || k == 9 || k == 13) ? 1 : 0);
    end
    chk("t1_done", done_irq, 1);
    rd(REG_CTRL, rv); chk("t1_ctrl", rv, 32'h4);

    // Gated looping sequence
    wr(REG_CTRL, 4);
    chk("t2_clr_done", done_irq, 0);
    wr(REG_TEMPO, 10); wr(REG_GATE, 6); wr(REG_LEN, 2);
    wr(TBL_BASE + 0, ent(1'b0, 8'h0F, 16'd500));
    wr(TBL_BASE + 1, ent(1'b0, 8'hF0, 16'd600));
    wr(REG_CTRL, 3);
    vld_cnt = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      st = ((k - 1) / 10) % 2;
      ph = (k - 1) % 10;
      chk("t2_freq", freq_out, (ph < 6) ? ((st == 1) ? 600 : 500) : 0);
      chk("t2_led", led_out, (st == 1) ? 32'hF0 : 32'h0F);
      if (k <= 20 && freq_vld) vld_cnt++;
    end
    chk("t2_vld_count", vld_cnt, 4);

    // Stop in GAP at tick 7, then restart from step 0
    repeat (5) @(negedge clk);
    chk("t4_busy_gap", busy, 1);
    chk("t4_freq_gap", freq_out, 0);
    wr(REG_CTRL, 2);
    chk("t4_busy_stop", busy, 0);
    rd(REG_STATUS, rv); chk("t4_status_idle", rv, 0);
    chk("t4_led_off", led_out, 0);
    chk("t4_freq_off", freq_out, 0);
    wr(REG_CTRL, 3);
    @(negedge clk);
    chk("t4_restart_freq", freq_out, 500);
    chk("t4_restart_led", led_out, 32'h0F);
    rd(REG_STATUS, rv); chk("t4_status_play", rv, 32'h10);

    // Zero TEMPO and LEN behave as one
    wr(REG_CTRL, 0);
    wr(REG_TEMPO, 0); wr(REG_LEN, 0);
    wr(REG_CTRL, 1);
    chk("t3_busy_start", busy, 1);
    @(negedge clk);
    chk("t3_freq", freq_out, 500);
    chk("t3_busy_end", busy, 0);
    chk("t3_done", done_irq, 1);
    @(negedge clk);
    chk("t3_freq_off", freq_out, 0);
    rd(REG_TEMPO, rv); chk("t3_tempo_raw", rv, 0);

    // Oversized LEN plays the full table
    wr(REG_CTRL, 4);
    chk("t3_clr_done", done_irq, 0);
    wr(REG_TEMPO, 2); wr(REG_GATE, 2); wr(REG_LEN, 40);
    for (int i = 0; i < 16; i++) wr(TBL_BASE + i, ent(1'b0, 8'(i), 16'(1000 + i)));
    rd(REG_LEN, rv); chk("t3_len_raw", rv, 40);
    rd(TBL_BASE + 5, rv); chk("t3_tbl_read", rv, ent(1'b0, 8'd5, 16'd1005));
    wr(REG_CTRL, 1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("t3_len_freq", freq_out, (k <= 32) ? (1000 + (k - 1) / 2) : 0);
      if (k == 31) chk("t3_busy_last", busy, 1);
      if (k == 32) begin
        chk("t3_busy_done", busy, 0);
        chk("t3_done_len", done_irq, 1);
      end
    end

    // Rest step and write to the playing entry
    wr(REG_CTRL, 4);
    wr(REG_TEMPO, 8); wr(REG_GATE, 8); wr(REG_LEN, 2);
    wr(TBL_BASE + 0, ent(1'b0, 8'hAA, 16'h111));
    wr(TBL_BASE + 1, ent(1'b1, 8'h55, 16'h222));
    wr(REG_CTRL, 3);
    @(negedge clk);
    chk("t6_step0", freq_out, 32'h111);
    @(negedge clk);
    wr(TBL_BASE + 0, ent(1'b0, 8'hAA, 16'h333));
    chk("t6_step0_after_wr", freq_out, 32'h111);
    repeat (5) @(negedge clk);
    chk("t6_step0_end", freq_out, 32'h111);
    @(negedge clk);
    chk("t6_rest_freq", freq_out, 0);
    chk("t6_rest_led", led_out, 32'h55);
    chk("t6_rest_vld", freq_vld, 1);
    repeat (7) @(negedge clk);
    chk("t6_rest_end", freq_out, 0);
    @(negedge clk);
    chk("t6_new_value", freq_out, 32'h333);
    chk("t6_new_vld", freq_vld, 1);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("t5_freq", freq_out, 0);
    chk("t5_led", led_out, 0);
    chk("t5_vld", freq_vld, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done_irq, 0);
    chk("t5_data", data_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(REG_TEMPO, rv);  chk("t5_tempo", rv, 1);
    rd(REG_STATUS, rv); chk("t5_status", rv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
